regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised integer register file for the pipelined RV32 core, next generation of the single-cycle regfile.
//  Adds generic width/depth, sequenced post-reset initialisation, and a per-register busy scoreboard for hazard detection.
//  Optional write-to-read bypass.
//  Sits between decode (reads, issue) and writeback (writes).
// PARAMETERS
//  XLEN     32       data width in bits
//  NREG     32       number of architectural registers, 2..32
//  AW       5        register index width, >= clog2(NREG)
//  SP_INIT  32'hff00 reset value of x2 (stack pointer)
//  FP_INIT  32'hff00 reset value of x8 (frame/base pointer)
//  DBG_IDX  10       register mirrored on dbg (a0)
// PORTS
//  clk      in   1     clock, all state updates on rising edge
//  reset    in   1     synchronous, active-high
//  ready    out  1     1 = init sequence finished, block accepts traffic
//  wr_req   in   1     writeback request
//  rd       in   AW    writeback register index
//  wr_data  in   XLEN  writeback data
//  iss_req  in   1     instruction issued that will write iss_rd
//  iss_rd   in   AW    destination of the issued instruction
//  rs1      in   AW    read port 1 index
//  rs2      in   AW    read port 2 index
//  rrs1     out  XLEN  read port 1 data (combinational)
//  rrs2     out  XLEN  read port 2 data (combinational)
//  busy1    out  1     rs1 has a pending write
//  busy2    out  1     rs2 has a pending write
//  dbg      out  XLEN  x[DBG_IDX] (combinational)
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous and active-high (reset).
//  - FSM states: INIT, RUN.
//    - reset=1 at an edge: state<=INIT, icnt<=0, ready<=0, all busy bits<=0.
//    - INIT: each cycle writes x[icnt] with its init value (x2=SP_INIT, x8=FP_INIT, others 0), then icnt++.
//    - After writing x[NREG-1]: state<=RUN, ready<=1. Init takes exactly NREG cycles after reset deasserts.
//    - Reset asserted mid-INIT or in RUN restarts the sequence from icnt=0.
//    - While ready=0: wr_req and iss_req are ignored; rrs1, rrs2, dbg, busy1 and busy2 read 0.
//  - Write (RUN only): wr_req=1, rd!=0, rd<NREG -> x[rd]<=wr_data at the edge. Visible to reads the next cycle.
//  - Reads: rrsN = x[rsN]. Returns 0 if rsN==0 or rsN>=NREG. x0 is hardwired 0 and never written.
//  - Scoreboard busy[NREG], bit 0 always 0. Updated in RUN only.
//    - iss_req=1 and iss_rd!=0 -> busy[iss_rd]<=1.
//    - wr_req=1 and rd!=0 -> busy[rd]<=0.
//    - Same index set and cleared in the same cycle: set wins (newer producer).
//  - busyN = busy[rsN], before any bypass qualification.
//  - A write to a register that is not busy is legal: data is written and busy stays 0.
//  - All widths are exact; no sign extension. Indices >= NREG: writes dropped, busy untouched.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//    - If wr_req=1, rd!=0, rd==rsN and ready=1, then rrsN=wr_data in the same cycle.
//    - busyN is forced to 0 for that port in that cycle. Zero-cycle write-to-read forwarding.
//  REGFILE_BYPASS_EN undefined:
//    - Reads return the pre-write value.
//    - busyN reflects the registered bit (still 1 in the writeback cycle).
// TESTING
//  - Reset 1 cycle, release -> ready=0 for 32 cycles then 1; x2=x8=0xff00, rrs1 with rs1=5 reads 0.
//  - Assert reset at init cycle 10 -> ready stays 0 for 32 further cycles; all init values correct.
//  - wr_req rd=0 wr_data=0xdead -> rrs1(rs1=0)=0; wr_req rd=10 wr_data=0x1234 -> dbg=0x1234 next cycle.
//  - iss_req iss_rd=7 -> busy1(rs1=7)=1; wr_req rd=7 iss_req iss_rd=7 same cycle -> busy stays 1;
//    wr_req rd=7 alone -> busy1=0 next cycle.
//  - Same-cycle wr_req rd=3 data=0xabcd with rs2=3:
//    - BYPASS_EN: rrs2=0xabcd and busy2=0 that cycle.
//    - Without: old value, then 0xabcd next cycle.
//  - Instance with NREG=16, AW=5: rs1=20 reads 0; wr_req rd=20 leaves x0..x15 unchanged.

Source files
------------

// File: rtl/regfile_sb.sv
// Parametrised integer register file with sequenced post-reset init and a per-register busy scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int              XLEN    = 32,
  parameter int              NREG    = 32,
  parameter int              AW      = 5,
  parameter logic [XLEN-1:0] SP_INIT = 32'hff00,
  parameter logic [XLEN-1:0] FP_INIT = 32'hff00,
  parameter int              DBG_IDX = 10
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ready,
  input  logic            wr_req,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] wr_data,
  input  logic            iss_req,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rrs1,
  output logic [XLEN-1:0] rrs2,
  output logic            busy1,
  output logic            busy2,
  output logic [XLEN-1:0] dbg
);

  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t          state, state_n;
  logic [AW-1:0]   icnt, icnt_n;
  logic            ready_n;
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy, busy_n;
  logic            wr_ok, iss_ok, rs1_ok, rs2_ok;
  logic            byp1, byp2;

  function automatic logic [XLEN-1:0] init_val(input logic [AW-1:0] idx);
    if (32'(idx) == 2)      return SP_INIT;
    else if (32'(idx) == 8) return FP_INIT;
    else                    return '0;
  endfunction

  // x0 and out-of-range indices never write, never mark busy and always read 0.
  assign wr_ok  = ready && wr_req  && (rd     != '0) && (32'(rd)     < NREG);
  assign iss_ok = ready && iss_req && (iss_rd != '0) && (32'(iss_rd) < NREG);
  assign rs1_ok = ready && (rs1 != '0) && (32'(rs1) < NREG);
  assign rs2_ok = ready && (rs2 != '0) && (32'(rs2) < NREG);

`ifdef REGFILE_BYPASS_EN
  assign byp1 = wr_ok && (rd == rs1);
  assign byp2 = wr_ok && (rd == rs2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      icnt  <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_n;
      icnt  <= icnt_n;
      ready <= ready_n;
    end
  end

  always_comb begin
    state_n = state;
    icnt_n  = icnt;
    ready_n = ready;
    case (state)
      INIT: begin
        if (32'(icnt) == NREG - 1) begin
          state_n = RUN;
          ready_n = 1'b1;
        end else begin
          icnt_n = icnt + AW'(1);
        end
      end
      RUN: begin
        state_n = RUN;
      end
      default: begin
        state_n = INIT;
      end
    endcase
  end

  // Register array has no reset: the INIT walk rewrites every entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) begin
        regs[icnt[IW-1:0]] <= init_val(icnt);
      end else if (wr_ok) begin
        regs[rd[IW-1:0]] <= wr_data;
      end
    end
  end

  // Clear first, then set, so a new issue to the same register wins over the retiring write.
  always_comb begin
    busy_n = busy;
    if (wr_ok)  busy_n[rd[IW-1:0]]     = 1'b0;
    if (iss_ok) busy_n[iss_rd[IW-1:0]] = 1'b1;
    busy_n[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else if (ready) begin
      busy <= busy_n;
    end
  end

  always_comb begin
    rrs1  = '0;
    rrs2  = '0;
    busy1 = 1'b0;
    busy2 = 1'b0;
    dbg   = '0;
    if (rs1_ok) begin
      rrs1  = byp1 ? wr_data : regs[rs1[IW-1:0]];
      busy1 = busy[rs1[IW-1:0]] && !byp1;
    end
    if (rs2_ok) begin
      rrs2  = byp2 ? wr_data : regs[rs2[IW-1:0]];
      busy2 = busy[rs2[IW-1:0]] && !byp2;
    end
    if (ready) dbg = regs[DBG_IDX];
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a default 32-entry instance and a 16-entry instance share all inputs.
// Expected values are queued per cycle by the stimulus and compared by a negedge monitor.
module tb_regfile_sb;

  localparam int S_READY   = 0;
  localparam int S_RRS1    = 1;
  localparam int S_RRS2    = 2;
  localparam int S_BUSY1   = 3;
  localparam int S_BUSY2   = 4;
  localparam int S_DBG     = 5;
  localparam int S_READY16 = 6;
  localparam int S_RRS1_16 = 7;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_req = 1'b0;
  logic        iss_req = 1'b0;
  logic [4:0]  rd = '0, iss_rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] wr_data = '0;

  logic        ready, busy1, busy2;
  logic [31:0] rrs1, rrs2, dbg;
  logic        ready16, busy1_16, busy2_16;
  logic [31:0] rrs1_16, rrs2_16, dbg16;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_sb dut (
    .clk(clk), .reset(reset), .ready(ready),
    .wr_req(wr_req), .rd(rd), .wr_data(wr_data),
    .iss_req(iss_req), .iss_rd(iss_rd),
    .rs1(rs1), .rs2(rs2), .rrs1(rrs1), .rrs2(rrs2),
    .busy1(busy1), .busy2(busy2), .dbg(dbg)
  );

  regfile_sb #(.NREG(16), .AW(5)) dut16 (
    .clk(clk), .reset(reset), .ready(ready16),
    .wr_req(wr_req), .rd(rd), .wr_data(wr_data),
    .iss_req(iss_req), .iss_rd(iss_rd),
    .rs1(rs1), .rs2(rs2), .rrs1(rrs1_16), .rrs2(rrs2_16),
    .busy1(busy1_16), .busy2(busy2_16), .dbg(dbg16)
  );

  function automatic logic [31:0] actual(input int sig);
    case (sig)
      S_READY:   return {31'd0, ready};
      S_RRS1:    return rrs1;
      S_RRS2:    return rrs2;
      S_BUSY1:   return {31'd0, busy1};
      S_BUSY2:   return {31'd0, busy2};
      S_DBG:     return dbg;
      S_READY16: return {31'd0, ready16};
      S_RRS1_16: return rrs1_16;
      default:   return 32'hxxxx_xxxx;
    endcase
  endfunction

  function automatic logic [31:0] initv(input int i);
    return (i == 2 || i == 8) ? 32'hff00 : 32'h0;
  endfunction

  // Contents of the 16-entry instance after the directed writes below.
  function automatic logic [31:0] exp16(input int i);
    case (i)
      2, 8:    return 32'hff00;
      3:       return 32'habcd;
      7:       return 32'h78;
      10:      return 32'h1234;
      default: return 32'h0;
    endcase
  endfunction

  // Monitor: compare every expectation queued for the current cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (actual(e.sig) !== e.exp) begin
        errors++;
        $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", e.name, actual(e.sig), e.exp, cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic w, input logic [4:0] r, input logic [31:0] d,
                               input logic i, input logic [4:0] ir,
                               input logic [4:0] a, input logic [4:0] b);
    wr_req  = w;
    rd      = r;
    wr_data = d;
    iss_req = i;
    iss_rd  = ir;
    rs1     = a;
    rs2     = b;
  endtask

  task automatic checkOutput(input int sig, input logic [31:0] e, input string n);
    sb.push_back('{cyc, sig, e, n});
  endtask

  initial begin
    // Plain reset then full init walk
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 2, 8);
    step();
    reset = 1'b0;
    checkOutput(S_READY, 0, "reset_ready");
    checkOutput(S_RRS1, 0, "reset_rrs1");
    checkOutput(S_DBG, 0, "reset_dbg");
    for (int i = 1; i <= 32; i++) begin
      step();
      checkOutput(S_READY, (i == 32) ? 32'd1 : 32'd0, "init_ready");
      checkOutput(S_READY16, (i >= 16) ? 32'd1 : 32'd0, "init_ready16");
    end
    checkOutput(S_RRS1, 32'hff00, "sp_init");
    checkOutput(S_RRS2, 32'hff00, "fp_init");
    checkOutput(S_RRS1_16, 32'hff00, "sp_init16");
    step();
    applyStimulus(0, 0, 0, 0, 0, 5, 8);
    checkOutput(S_RRS1, 0, "x5_init");
    step();

    // Reset again, then reset once more at init cycle 10
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput(S_READY, 0, "rerun_ready0");
    for (int i = 1; i <= 32; i++) begin
      step();
      checkOutput(S_READY, (i == 32) ? 32'd1 : 32'd0, "rerun_ready");
    end
    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
      checkOutput(S_RRS1, initv(i), "init_val_rs1");
      checkOutput(S_RRS2, initv(31 - i), "init_val_rs2");
      checkOutput(S_RRS1_16, (i < 16) ? initv(i) : 32'h0, "init_val16");
      step();
    end

    // x0 writes are dropped; ordinary write shows on dbg a cycle later
    applyStimulus(1, 0, 32'hdead, 0, 0, 0, 0);
    checkOutput(S_RRS1, 0, "x0_write_same");
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput(S_RRS1, 0, "x0_write_after");
    step();
    applyStimulus(1, 10, 32'h1234, 0, 0, 0, 0);
    checkOutput(S_DBG, 0, "dbg_before");
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput(S_DBG, 32'h1234, "dbg_after");
    step();

    // Scoreboard on x7: set, simultaneous set/clear, clear
    applyStimulus(0, 0, 0, 1, 7, 7, 0);
    checkOutput(S_BUSY1, 0, "busy7_pre");
    step();
    applyStimulus(1, 7, 32'h77, 1, 7, 7, 0);
    checkOutput(S_BUSY1, BYP ? 32'd0 : 32'd1, "busy7_setclr_same");
    checkOutput(S_RRS1, BYP ? 32'h77 : 32'h0, "x7_setclr_read");
    step();
    applyStimulus(0, 0, 0, 0, 0, 7, 0);
    checkOutput(S_BUSY1, 1, "busy7_set_wins");
    checkOutput(S_RRS1, 32'h77, "x7_written");
    step();
    applyStimulus(1, 7, 32'h78, 0, 0, 7, 0);
    checkOutput(S_BUSY1, BYP ? 32'd0 : 32'd1, "busy7_wb_cycle");
    step();
    applyStimulus(0, 0, 0, 0, 0, 7, 0);
    checkOutput(S_BUSY1, 0, "busy7_cleared");
    checkOutput(S_RRS1, 32'h78, "x7_rewritten");
    step();

    // Write to a busy x3 read on port 2 in the same cycle
    applyStimulus(0, 0, 0, 1, 3, 0, 3);
    checkOutput(S_BUSY2, 0, "busy3_pre");
    step();
    applyStimulus(1, 3, 32'habcd, 0, 0, 0, 3);
    checkOutput(S_BUSY2, BYP ? 32'd0 : 32'd1, "busy3_wb_cycle");
    checkOutput(S_RRS2, BYP ? 32'habcd : 32'h0, "x3_same_cycle");
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 3);
    checkOutput(S_RRS2, 32'habcd, "x3_next_cycle");
    checkOutput(S_BUSY2, 0, "busy3_cleared");
    step();

    // Index 20 exists only in the 32-entry instance
    applyStimulus(1, 20, 32'h5555, 1, 20, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 20, 20);
    checkOutput(S_RRS1_16, 0, "oob_read16");
    checkOutput(S_RRS2, 32'h5555, "x20_write32");
    step();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 5'(i), 0);
      checkOutput(S_RRS1_16, exp16(i), "x16_unchanged");
      step();
    end

    // Reset while RUN clears busy and drops ready
    applyStimulus(0, 0, 0, 1, 5, 5, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 5, 0);
    checkOutput(S_BUSY1, 1, "busy5_set");
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput(S_READY, 0, "run_reset_ready");
    checkOutput(S_BUSY1, 0, "run_reset_busy");
    checkOutput(S_RRS1, 0, "run_reset_rrs1");
    step();
    step();

    if (sb.size() > 0) begin
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      errors += sb.size();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
